// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial add/subtract sequencer. One shared 1-bit adder slice
//            processes two WIDTH-bit operands LSB-first, one bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_ra;
    logic [WIDTH-1:0]   r_rb;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_overflow;

    // Shared bit slice: two half adders with OR-combined carries
    logic               w_s1;
    logic               w_c1;
    logic               w_s;
    logic               w_c2;
    logic               w_carry_next;
    logic [WIDTH-1:0]   w_acc_next;

    assign w_s1         = r_ra[0] ^ r_rb[0];
    assign w_c1         = r_ra[0] & r_rb[0];
    assign w_s          = w_s1 ^ r_carry;
    assign w_c2         = w_s1 & r_carry;
    assign w_carry_next = w_c1 | w_c2;
    assign w_acc_next   = {w_s, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ra       <= '0;
            r_rb       <= '0;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry
            r_ra    <= a;
            r_rb    <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        end else if (r_state == S_RUN) begin
            r_ra    <= {1'b0, r_ra[WIDTH-1:1]};
            r_rb    <= {1'b0, r_rb[WIDTH-1:1]};
            r_acc   <= w_acc_next;
            r_carry <= w_carry_next;
            r_cnt   <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
                r_sum      <= w_acc_next;
                r_cout     <= w_carry_next;
                r_overflow <= (r_a_msb == r_b_msb) && (w_s != r_a_msb);
            end
        end
    end

    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer for a bit-serial adder/subtractor built around one shared 1-bit adder datapath: two half-adder stages plus an OR for carry.
- Accepts two WIDTH-bit operands on a start pulse and feeds them LSB-first through the shared adder, one bit per clock.
- Accumulates the result in a shift register and presents sum, carry and signed overflow with a one-cycle done pulse.
- Used wherever area matters more than latency; the shared adder is reused WIDTH times per operation.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range >= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a new operation; honoured only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse: result registers updated.
- sum  output  WIDTH  result; holds the last completed value.
- cout  output  1  final carry; in sub mode, 1 = no borrow.
- overflow  output  1  two's-complement overflow of the last result.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low, on rst_n.
- Reset (rst_n=0 at a rising edge):
  - state forced to IDLE; busy=0, done=0, sum=0, cout=0, overflow=0.
  - internal operand/shift registers, carry flop and bit counter cleared.
  - Reset overrides everything, including mid-RUN; no partial result is published.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE, start=1:
  - capture ra=a, rb = sub ? ~b : b, carry=sub, cnt=0.
  - latch sub and the operand MSBs a[WIDTH-1] and rb[WIDTH-1] for overflow.
  - go to RUN. start=0 stays in IDLE.
- RUN, each edge, on the shared bit-slice:
  - s1=ra[0]^rb[0], c1=ra[0]&rb[0]; s=s1^carry, c2=s1&carry.
  - carry<=c1|c2.
  - ra and rb shift right by one; the accumulator shifts right with s inserted at bit WIDTH-1; cnt<=cnt+1.
  - When cnt==WIDTH-1 on this edge, go to DONE, loading the output registers with the completed value: sum<=final accumulator, cout<=final carry, overflow<=(opA_msb==opB_msb)&&(sum_msb!=opA_msb).
- DONE: done=1 for exactly this one cycle; unconditionally return to IDLE on the next edge.
- Output timing:
  - busy is high only in RUN; done is high only in DONE; the two are never high together.
  - sum/cout/overflow change only on the edge entering DONE and hold their value through IDLE and later RUNs until the next DONE.
- Latency: done rises at the WIDTH-th rising edge after the edge that accepted start. Minimum start-to-start spacing is WIDTH+2 cycles.
- start in RUN or DONE is ignored: no queueing, no effect on the in-flight operation. a/b/sub changes after acceptance have no effect.
- Arithmetic:
  - result is modulo 2^WIDTH.
  - sub uses the two's complement form a + ~b + 1.
  - the counter must be wide enough for WIDTH-1: $clog2(WIDTH) bits, minimum 1.

Test Plan:
1. WIDTH=8, reset, then start with a=3, b=5, sub=0 -> busy for 8 cycles; done pulses 8 edges after acceptance; sum=8, cout=0, overflow=0.
2. a=255, b=1, sub=0 -> sum=0, cout=1, overflow=0. Then a=127, b=1, sub=0 -> sum=128, cout=0, overflow=1.
3. a=5, b=3, sub=1 -> sum=2, cout=1. Then a=3, b=5, sub=1 -> sum=254, cout=0, overflow=0. Then a=128, b=1, sub=1 -> sum=127, overflow=1.
4. Start a=10, b=20; pulse start again with a=1, b=1 at RUN cycle 3 and during DONE -> single done; sum=30; returns to IDLE.
5. After a completed result sum=8, start a=100, b=50, then drop rst_n for one edge at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0, overflow=0. A fresh start with a=1, b=2 then yields sum=3.
6. Back-to-back: assert start on the first IDLE cycle after each done, for 4 random pairs -> each result matches the modular reference model, and done pulses are spaced exactly WIDTH+2 cycles apart.
